// File: rtl/mem_imm_hazard.sv
// Unified 256-byte instruction/data memory, ID-stage immediate decoder and
// load-use hazard detector for the pipelined RV32I core.
module mem_imm_hazard (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [7:0]  mem_addr,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_data_out,
    input  logic [31:0] inst,
    output logic [31:0] imm_out,
    input  logic [4:0]  if_id_rs1,
    input  logic [4:0]  if_id_rs2,
    input  logic [4:0]  id_ex_rd,
    input  logic        id_ex_mem_read,
    output logic        stall
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [31:0] mem_q [0:63];
    logic [31:0] mem_word_d;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [5:0]  word_idx;

    assign word_idx = mem_addr[7:2];

    // Read path and read-modify-write merge share the addressed word.
    always_comb begin
        rd_word  = mem_q[word_idx];
        rd_shift = rd_word >> {mem_addr[1:0], 3'b000};
        rd_byte  = rd_shift[7:0];
        rd_half  = mem_addr[1] ? rd_word[31:16] : rd_word[15:0];

        mem_data_out = 32'h0;
        if (mem_read && !rst) begin
            case (funct3)
                F3_B:    mem_data_out = {{24{rd_byte[7]}}, rd_byte};
                F3_BU:   mem_data_out = {24'h0, rd_byte};
                F3_H:    mem_data_out = {{16{rd_half[15]}}, rd_half};
                F3_HU:   mem_data_out = {16'h0, rd_half};
                default: mem_data_out = rd_word;
            endcase
        end

        mem_word_d = rd_word;
        case (funct3)
            F3_B: begin
                case (mem_addr[1:0])
                    2'd0:    mem_word_d[7:0]   = mem_data_in[7:0];
                    2'd1:    mem_word_d[15:8]  = mem_data_in[7:0];
                    2'd2:    mem_word_d[23:16] = mem_data_in[7:0];
                    default: mem_word_d[31:24] = mem_data_in[7:0];
                endcase
            end
            F3_H: begin
                if (mem_addr[1]) mem_word_d[31:16] = mem_data_in[15:0];
                else             mem_word_d[15:0]  = mem_data_in[15:0];
            end
            default: mem_word_d = mem_data_in;
        endcase
    end

    // Memory contents survive reset; reset only blocks writes.
    always_ff @(posedge clk) begin
        if (mem_write && !rst) begin
            mem_q[word_idx] <= mem_word_d;
        end
    end

    always_comb begin
        imm_out = 32'h0;
        case (inst[6:0])
            7'b0000011, 7'b1100111: imm_out = {{20{inst[31]}}, inst[31:20]};
            7'b0010011: begin
                if (inst[14:12] == 3'b001 || inst[14:12] == 3'b101)
                    imm_out = {27'h0, inst[24:20]};
                else
                    imm_out = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0100011: imm_out = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            7'b1100011: imm_out = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            7'b0110111, 7'b0010111: imm_out = {inst[31:12], 12'h0};
            7'b1101111: imm_out = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm_out = 32'h0;
        endcase
    end

    // rs2 is compared even for instructions that do not read it.
    always_comb begin
        stall = 1'b0;
        if (!rst && id_ex_mem_read && (id_ex_rd != 5'd0) &&
            ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2)))
            stall = 1'b1;
    end

endmodule

// File: tb/tb_mem_imm_hazard.sv
// Directed bench for mem_imm_hazard: loads/stores, immediates, stall and
// asynchronous reset behaviour, checked through an expected-value queue.
module tb_mem_imm_hazard;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic [31:0] inst;
    logic [31:0] imm_out;
    logic [4:0]  if_id_rs1;
    logic [4:0]  if_id_rs2;
    logic [4:0]  id_ex_rd;
    logic        id_ex_mem_read;
    logic        stall;

    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    mem_imm_hazard dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3         (funct3),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .inst           (inst),
        .imm_out        (imm_out),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2),
        .id_ex_rd       (id_ex_rd),
        .id_ex_mem_read (id_ex_mem_read),
        .stall          (stall)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic compare(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic store(input logic [7:0] a, input logic [2:0] f, input logic [31:0] d);
        @(negedge clk);
        mem_write   = 1'b1;
        mem_addr    = a;
        funct3      = f;
        mem_data_in = d;
        @(negedge clk);
        mem_write   = 1'b0;
    endtask

    task automatic load(input string tag, input logic [7:0] a, input logic [2:0] f,
                        input logic [31:0] e);
        @(negedge clk);
        mem_read = 1'b1;
        mem_addr = a;
        funct3   = f;
        expect_val(e);
        #1;
        compare(tag, mem_data_out);
    endtask

    task automatic check_imm(input string tag, input logic [31:0] i, input logic [31:0] e);
        inst = i;
        expect_val(e);
        #1;
        compare(tag, imm_out);
    endtask

    task automatic check_stall(input string tag, input logic mr, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic e);
        id_ex_mem_read = mr;
        id_ex_rd       = rd;
        if_id_rs1      = rs1;
        if_id_rs2      = rs2;
        expect_val({31'h0, e});
        #1;
        compare(tag, {31'h0, stall});
    endtask

    logic [31:0] model_word;
    logic [31:0] rnd_data;
    logic [7:0]  rnd_byte;
    logic [1:0]  rnd_lane;
    logic [7:0]  rnd_addr;

    initial begin
        rst = 1'b1;
        mem_read = 1'b1;
        mem_write = 1'b0;
        funct3 = 3'b010;
        mem_addr = 8'h00;
        mem_data_in = 32'h0;
        inst = 32'h0;
        if_id_rs1 = 5'd0;
        if_id_rs2 = 5'd0;
        id_ex_rd = 5'd0;
        id_ex_mem_read = 1'b0;

        // reset state: outputs forced low, immediate still decoded
        check_stall("rst_stall", 1'b1, 5'd7, 5'd7, 5'd1, 1'b0);
        expect_val(32'h0);
        compare("rst_rdata", mem_data_out);
        check_imm("rst_imm_lui", 32'h123452B7, 32'h1234_5000);
        @(negedge clk);
        rst = 1'b0;

        // sub-word loads from word 4
        store(8'h10, 3'b010, 32'h8081_F0F2);
        load("lb_10",  8'h10, 3'b000, 32'hFFFF_FFF2);
        load("lbu_10", 8'h10, 3'b100, 32'h0000_00F2);
        load("lh_10",  8'h10, 3'b001, 32'hFFFF_F0F2);
        load("lh_11",  8'h11, 3'b001, 32'hFFFF_F0F2);
        load("lhu_12", 8'h12, 3'b101, 32'h0000_8081);
        load("lb_13",  8'h13, 3'b000, 32'hFFFF_FF80);
        load("lw_10",  8'h10, 3'b010, 32'h8081_F0F2);
        load("lw_13",  8'h13, 3'b010, 32'h8081_F0F2);
        load("f3_011", 8'h10, 3'b011, 32'h8081_F0F2);

        // byte and halfword stores merge into word 8
        store(8'h20, 3'b010, 32'h1122_3344);
        store(8'h21, 3'b000, 32'hFFFF_FFAB);
        load("sb_21", 8'h20, 3'b010, 32'h1122_AB44);
        store(8'h22, 3'b001, 32'h1234_BEEF);
        load("sh_22", 8'h20, 3'b010, 32'hBEEF_AB44);

        // write during reset is dropped; reads are zero while in reset
        @(negedge clk);
        rst = 1'b1;
        mem_write = 1'b1;
        mem_read = 1'b1;
        mem_addr = 8'h20;
        funct3 = 3'b010;
        mem_data_in = 32'hDEAD_BEEF;
        expect_val(32'h0);
        #1;
        compare("rd_in_rst", mem_data_out);
        @(negedge clk);
        mem_write = 1'b0;
        rst = 1'b0;
        expect_val(32'hBEEF_AB44);
        #1;
        compare("wr_in_rst", mem_data_out);

        // mem_read low gates the output
        @(negedge clk);
        mem_read = 1'b0;
        expect_val(32'h0);
        #1;
        compare("rd_off", mem_data_out);

        // same-address write: old value before the edge, new after
        store(8'h30, 3'b010, 32'h0BAD_F00D);
        @(negedge clk);
        mem_read = 1'b1;
        mem_addr = 8'h30;
        funct3 = 3'b010;
        mem_write = 1'b1;
        mem_data_in = 32'hCAFE_0001;
        expect_val(32'h0BAD_F00D);
        #1;
        compare("wr_old", mem_data_out);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        expect_val(32'hCAFE_0001);
        compare("wr_new", mem_data_out);

        // randomized word store plus one random byte store per word
        for (int i = 0; i < 6; i++) begin
            rnd_addr = 8'h40 + 8'($urandom_range(0, 15) * 4);
            rnd_data = $urandom;
            rnd_lane = 2'($urandom_range(0, 3));
            rnd_byte = 8'($urandom_range(0, 255));
            store(rnd_addr, 3'b010, rnd_data);
            load("rnd_lw", rnd_addr, 3'b010, rnd_data);
            model_word = rnd_data;
            model_word[8*rnd_lane +: 8] = rnd_byte;
            store(rnd_addr | 8'(rnd_lane), 3'b000, {24'hFFFFFF, rnd_byte});
            load("rnd_sb", rnd_addr, 3'b010, model_word);
            load("rnd_lbu", rnd_addr | 8'(rnd_lane), 3'b100, {24'h0, rnd_byte});
        end

        // immediates
        check_imm("imm_addi", 32'hFFF00093, 32'hFFFF_FFFF);
        check_imm("imm_srai", 32'h40515093, 32'h0000_0005);
        check_imm("imm_beq",  32'hFE000EE3, 32'hFFFF_FFFC);
        check_imm("imm_lui",  32'h123452B7, 32'h1234_5000);
        check_imm("imm_jal",  32'h008000EF, 32'h0000_0008);
        check_imm("imm_sw",   32'hFE112E23, 32'hFFFF_FFFC);
        check_imm("imm_bad",  32'hFFFFFFFF, 32'h0000_0000);

        // load-use stall
        @(negedge clk);
        check_stall("stall_rs1",  1'b1, 5'd5, 5'd5, 5'd1, 1'b1);
        check_stall("stall_rs2",  1'b1, 5'd5, 5'd2, 5'd5, 1'b1);
        check_stall("stall_x0",   1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        check_stall("stall_nold", 1'b0, 5'd5, 5'd5, 5'd5, 1'b0);
        check_stall("stall_nom",  1'b1, 5'd5, 5'd6, 5'd7, 1'b0);

        // asynchronous reset mid-cycle while stalling
        @(negedge clk);
        check_stall("stall_pre", 1'b1, 5'd9, 5'd9, 5'd0, 1'b1);
        rst = 1'b1;
        expect_val(32'h0);
        #1;
        compare("stall_async", {31'h0, stall});
        rst = 1'b0;
        expect_val(32'h1);
        #1;
        compare("stall_resume", {31'h0, stall});

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
